// File: rtl/alu_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_packer
// Description : Packs ALU results LSB-first into a wide packet buffer and
//               offers the packet through a valid/ready handshake. Optional
//               XOR checksum enabled by macro ALU_RESULT_PACKER_CSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_packer #(
    parameter int RES_WIDTH = 16,
    parameter int NUM_RES   = 256,
    parameter int CNT_W     = 9
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           done_i,
    input  logic [RES_WIDTH-1:0]           result_i,
    input  logic                           flush_i,
    input  logic                           pkt_ready_i,
    output logic                           pkt_valid_o,
    output logic [RES_WIDTH*NUM_RES-1:0]   pkt_data_o,
    output logic [CNT_W-1:0]               pkt_count_o,
    output logic [7:0]                     drop_cnt_o,
    output logic [RES_WIDTH-1:0]           pkt_csum_o
);

    localparam logic [0:0]       FILL      = 1'b0;
    localparam logic [0:0]       HOLD      = 1'b1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_RES - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       drop_q, drop_d;
    logic             wr_en;
    logic             clr;
    logic [CNT_W-1:0] wr_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;
        clr     = 1'b0;
        wr_idx  = cnt_q;
        case (state_q)
            FILL: begin
                wr_en = done_i;
                if (done_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A coincident done is captured before the flush takes effect
                if ((done_i && (cnt_q == LAST_SLOT)) ||
                    (flush_i && ((cnt_q != '0) || done_i))) begin
                    state_d = HOLD;
                end
            end
            default: begin
                if (pkt_ready_i) begin
                    // A done in the handshake cycle opens the next packet at slot 0
                    clr     = 1'b1;
                    state_d = FILL;
                    wr_en   = done_i;
                    wr_idx  = '0;
                    cnt_d   = done_i ? CNT_W'(1) : '0;
                end else if (done_i && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= FILL;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_RES; i++) begin : g_slot
            logic [RES_WIDTH-1:0] slot_q;
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    slot_q <= '0;
                end else if (wr_en && (wr_idx == CNT_W'(i))) begin
                    slot_q <= result_i;
                end else if (clr) begin
                    slot_q <= '0;
                end
            end
            assign pkt_data_o[i*RES_WIDTH +: RES_WIDTH] = slot_q;
        end
    endgenerate

`ifdef ALU_RESULT_PACKER_CSUM_EN
    logic [RES_WIDTH-1:0] csum_q, csum_d, csum_base;

    always_comb begin
        csum_base = clr ? '0 : csum_q;
        csum_d    = wr_en ? (csum_base ^ result_i) : csum_base;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign pkt_csum_o = csum_q;
`else
    assign pkt_csum_o = '0;
`endif

    assign pkt_valid_o = (state_q == HOLD);
    assign pkt_count_o = cnt_q;
    assign drop_cnt_o  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_packer.sv
`default_nettype none
// Testbench for alu_result_packer: directed scenarios plus randomized traffic
// checked against a queue-based packet model.
module tb_alu_result_packer;

    localparam int RW = 16;
    localparam int NR = 256;
    localparam int CW = 9;
    localparam int DW = RW * NR;
`ifdef ALU_RESULT_PACKER_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          done_i = 1'b0;
    logic [RW-1:0] result_i = '0;
    logic          flush_i = 1'b0;
    logic          pkt_ready_i = 1'b0;
    logic          pkt_valid_o;
    logic [DW-1:0] pkt_data_o;
    logic [CW-1:0] pkt_count_o;
    logic [7:0]    drop_cnt_o;
    logic [RW-1:0] pkt_csum_o;

    int total = 0;
    int bad   = 0;

    // Reference model: the current packet is simply the list of its results
    logic [RW-1:0] mq[$];
    bit            mhold = 1'b0;
    int            mdrop = 0;

    alu_result_packer #(.RES_WIDTH(RW), .NUM_RES(NR), .CNT_W(CW)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .done_i      (done_i),
        .result_i    (result_i),
        .flush_i     (flush_i),
        .pkt_ready_i (pkt_ready_i),
        .pkt_valid_o (pkt_valid_o),
        .pkt_data_o  (pkt_data_o),
        .pkt_count_o (pkt_count_o),
        .drop_cnt_o  (drop_cnt_o),
        .pkt_csum_o  (pkt_csum_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_data();
        logic [DW-1:0] v = '0;
        foreach (mq[i]) v[i*RW +: RW] = mq[i];
        return v;
    endfunction

    function automatic logic [RW-1:0] exp_csum();
        logic [RW-1:0] x = '0;
        if (CSUM_ON) foreach (mq[i]) x ^= mq[i];
        return x;
    endfunction

    function automatic int diff_slot(logic [DW-1:0] a, logic [DW-1:0] b);
        for (int i = 0; i < NR; i++)
            if (a[i*RW +: RW] !== b[i*RW +: RW]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        mhold = 1'b0;
        mdrop = 0;
    endtask

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge
    task automatic drive(input bit d, input logic [RW-1:0] r, input bit f, input bit rd);
        done_i = d; result_i = r; flush_i = f; pkt_ready_i = rd;
        if (!mhold) begin
            if (d) mq.push_back(r);
            if (mq.size() == NR || (f && mq.size() > 0)) mhold = 1'b1;
        end else if (rd) begin
            mq.delete();
            mhold = 1'b0;
            if (d) mq.push_back(r);
        end else if (d && mdrop < 255) begin
            mdrop++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        #3;
        total++; if (pkt_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", pkt_valid_o); end
        total++; if (pkt_data_o !== '0) begin bad++; $display("FAIL reset_data first nonzero slot=%0d", diff_slot(pkt_data_o, '0)); end
        total++; if (pkt_count_o !== '0) begin bad++; $display("FAIL reset_count got=%0d want=0", pkt_count_o); end
        total++; if (drop_cnt_o !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt_o); end
        total++; if (pkt_csum_o !== '0) begin bad++; $display("FAIL reset_csum got=%h want=0", pkt_csum_o); end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        model_reset();
    endtask

    task automatic test_full_packet();
        for (int k = 0; k < NR; k++) begin
            drive(1'b1, RW'(k), 1'b0, 1'b0);
            if (k == 0) begin
                total++; if (pkt_data_o[RW-1:0] !== 16'h0000 || pkt_count_o !== CW'(1)) begin
                    bad++; $display("FAIL full_first count got=%0d want=1", pkt_count_o); end
            end
            if (k == NR - 2) begin
                total++; if (pkt_valid_o !== 1'b0) begin bad++; $display("FAIL full_early_valid got=%0b want=0", pkt_valid_o); end
            end
        end
        total++; if (pkt_valid_o !== 1'b1) begin bad++; $display("FAIL full_valid got=%0b want=1", pkt_valid_o); end
        total++; if (pkt_count_o !== CW'(256)) begin bad++; $display("FAIL full_count got=%0d want=256", pkt_count_o); end
        total++; if (pkt_data_o !== exp_data()) begin bad++; $display("FAIL full_data first bad slot=%0d", diff_slot(pkt_data_o, exp_data())); end
        total++; if (pkt_csum_o !== 16'h0000) begin bad++; $display("FAIL full_csum got=%h want=0000", pkt_csum_o); end
    endtask

    task automatic test_flush_coincident();
        drive(1'b0, '0, 1'b0, 1'b1);
        total++; if (pkt_valid_o !== 1'b0 || pkt_count_o !== '0) begin
            bad++; $display("FAIL hs_clear valid=%0b count=%0d want 0/0", pkt_valid_o, pkt_count_o); end
        drive(1'b1, 16'h1111, 1'b0, 1'b0);
        drive(1'b1, 16'h2222, 1'b0, 1'b0);
        drive(1'b1, 16'h3333, 1'b1, 1'b0);
        total++; if (pkt_valid_o !== 1'b1) begin bad++; $display("FAIL flush_valid got=%0b want=1", pkt_valid_o); end
        total++; if (pkt_count_o !== CW'(3)) begin bad++; $display("FAIL flush_count got=%0d want=3", pkt_count_o); end
        total++; if (pkt_data_o !== exp_data() || pkt_data_o[47:0] !== 48'h3333_2222_1111) begin
            bad++; $display("FAIL flush_data first bad slot=%0d", diff_slot(pkt_data_o, exp_data())); end
        total++; if (pkt_csum_o !== 16'h0000) begin bad++; $display("FAIL flush_csum got=%h want=0000", pkt_csum_o); end
    endtask

    task automatic test_drops();
        for (int k = 0; k < 300; k++) drive(1'b1, RW'($urandom), $urandom_range(0, 1) == 1, 1'b0);
        total++; if (drop_cnt_o !== 8'd255 || mdrop != 255) begin bad++; $display("FAIL drop_sat got=%0d want=255", drop_cnt_o); end
        total++; if (pkt_data_o !== exp_data()) begin bad++; $display("FAIL drop_data first bad slot=%0d", diff_slot(pkt_data_o, exp_data())); end
        total++; if (pkt_valid_o !== 1'b1 || pkt_count_o !== CW'(3)) begin
            bad++; $display("FAIL drop_hold valid=%0b count=%0d want 1/3", pkt_valid_o, pkt_count_o); end
    endtask

    task automatic test_handshake_done();
        drive(1'b1, 16'hBEEF, 1'b0, 1'b1);
        total++; if (pkt_valid_o !== 1'b0) begin bad++; $display("FAIL hsd_valid got=%0b want=0", pkt_valid_o); end
        total++; if (pkt_count_o !== CW'(1)) begin bad++; $display("FAIL hsd_count got=%0d want=1", pkt_count_o); end
        total++; if (pkt_data_o !== exp_data() || pkt_data_o[RW-1:0] !== 16'hBEEF) begin
            bad++; $display("FAIL hsd_slot0 got=%h want=beef", pkt_data_o[RW-1:0]); end
        total++; if (drop_cnt_o !== 8'd255) begin bad++; $display("FAIL hsd_drop got=%0d want=255", drop_cnt_o); end
        total++; if (pkt_csum_o !== (CSUM_ON ? 16'hBEEF : 16'h0000)) begin bad++; $display("FAIL hsd_csum got=%h want=%h", pkt_csum_o, exp_csum()); end
    endtask

    task automatic test_idle_flush();
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, RW'($urandom), 1'b1, 1'b0);
            total++; if (pkt_valid_o !== 1'b0 || pkt_count_o !== '0) begin
                bad++; $display("FAIL idle_flush valid=%0b count=%0d want 0/0", pkt_valid_o, pkt_count_o); end
        end
    endtask

    task automatic test_back_to_back();
        int run = 0;
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, RW'($urandom), (k % 2) == 1, 1'b1);
            run = pkt_valid_o ? run + 1 : 0;
            total++; if (pkt_valid_o !== mhold || pkt_count_o !== CW'(mq.size()) || run > 1) begin
                bad++; $display("FAIL b2b cyc=%0d valid=%0b count=%0d want %0b/%0d", k, pkt_valid_o, pkt_count_o, mhold, mq.size()); end
            total++; if (pkt_data_o !== exp_data() || pkt_csum_o !== exp_csum()) begin
                bad++; $display("FAIL b2b_data cyc=%0d slot=%0d csum=%h want=%h", k, diff_slot(pkt_data_o, exp_data()), pkt_csum_o, exp_csum()); end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 100; k++) drive(1'b1, RW'($urandom) | 16'h0001, 1'b0, 1'b0);
        #2;
        reset_i = 1'b1;
        #1;
        total++; if (pkt_valid_o !== 1'b0 || pkt_count_o !== '0 || drop_cnt_o !== 8'd0 || pkt_csum_o !== '0) begin
            bad++; $display("FAIL areset_regs valid=%0b count=%0d drop=%0d csum=%h want all 0", pkt_valid_o, pkt_count_o, drop_cnt_o, pkt_csum_o); end
        total++; if (pkt_data_o !== '0) begin bad++; $display("FAIL areset_data first nonzero slot=%0d", diff_slot(pkt_data_o, '0)); end
        #1;
        reset_i = 1'b0;
        model_reset();
        drive(1'b1, 16'h5A5A, 1'b0, 1'b0);
        total++; if (pkt_count_o !== CW'(1) || pkt_data_o !== exp_data()) begin
            bad++; $display("FAIL areset_next count=%0d slot0=%h want 1/5a5a", pkt_count_o, pkt_data_o[RW-1:0]); end
    endtask

    task automatic test_random();
        reset_i = 1'b1;
        #1;
        reset_i = 1'b0;
        model_reset();
        for (int k = 0; k < 2000; k++) begin
            drive($urandom_range(0, 2) != 0, RW'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
            total++; if (pkt_valid_o !== mhold || pkt_count_o !== CW'(mq.size()) || drop_cnt_o !== 8'(mdrop)) begin
                bad++; $display("FAIL rand cyc=%0d valid=%0b count=%0d drop=%0d want %0b/%0d/%0d", k, pkt_valid_o, pkt_count_o, drop_cnt_o, mhold, mq.size(), mdrop); end
            total++; if (pkt_data_o !== exp_data() || pkt_csum_o !== exp_csum()) begin
                bad++; $display("FAIL rand_data cyc=%0d slot=%0d csum=%h want=%h", k, diff_slot(pkt_data_o, exp_data()), pkt_csum_o, exp_csum()); end
        end
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_flush_coincident();
        test_drops();
        test_handshake_done();
        test_idle_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
